// File: rtl/pixel_hsmooth.sv
// pixel_hsmooth: horizontal 3-tap (1-2-1)/4 per-channel RGB smoothing on an Avalon-ST video stream
// Ports: clk, reset_n (synchronous, active-low)
//        sink_data/valid/ready/sop/eop     : upstream Avalon-ST, {R,G,B} 8 bits each
//        source_data/valid/ready/sop/eop   : downstream Avalon-ST, filtered {R,G,B}
//        enable                            : 1 = filter, 0 = bypass; latched on each accepted sop
module pixel_hsmooth #(
  parameter int IMAGE_W = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        enable
);
  typedef enum logic [2:0] {S_HDR, S_PASS, S_FIRST, S_RUN, S_FLUSH} state_t;
  localparam logic [10:0] LAST = 11'(IMAGE_W - 1);
  state_t      r_state, w_nxt;
  logic        r_alive, r_en, r_cur_eop;
  logic [23:0] r_prev, r_cur;
  logic [10:0] r_x;
  logic        w_free, w_acc, w_hdr, w_last, w_emit, w_sop, w_eop;
  logic [23:0] w_data, w_run, w_fl;

  function automatic logic [23:0] filt(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    logic [9:0] s;
    filt = '0;
    for (int i = 0; i < 3; i++) begin
      s = 10'(a[8*i+:8]) + {1'b0, b[8*i+:8], 1'b0} + 10'(c[8*i+:8]) + 10'd2;
      filt[8*i+:8] = s[9:2];
    end
  endfunction

  assign w_free     = ~source_valid | source_ready;
  // r_alive holds ready low for the first cycle after reset release
  assign sink_ready = r_alive & w_free & (r_state != S_FLUSH);
  assign w_acc      = sink_valid & sink_ready;
  // any sop outside a pass-through packet restarts header processing
  assign w_hdr      = w_acc & sink_sop & (r_state != S_PASS);
  assign w_last     = (r_x + 11'd1 == LAST);
  assign w_run      = r_en ? filt(r_prev, r_cur, sink_data) : r_cur;
  assign w_fl       = r_en ? filt(r_prev, r_cur, r_cur) : r_cur;

  always_comb begin
    w_nxt  = r_state;
    w_emit = 1'b0;
    w_data = '0;
    w_sop  = 1'b0;
    w_eop  = 1'b0;
    if (w_hdr) begin
      w_emit = 1'b1;
      w_data = sink_data;
      w_sop  = 1'b1;
      w_eop  = sink_eop;
      w_nxt  = (sink_data[3:0] == 4'd0) ? S_FIRST : S_PASS;
    end else if (w_acc && r_state == S_PASS) begin
      w_emit = 1'b1;
      w_data = sink_data;
      w_sop  = sink_sop;
      w_eop  = sink_eop;
      w_nxt  = sink_eop ? S_HDR : S_PASS;
    end else if (w_acc && r_state == S_FIRST) begin
      w_nxt = (sink_eop || IMAGE_W < 2) ? S_FLUSH : S_RUN;
    end else if (w_acc && r_state == S_RUN) begin
      w_emit = 1'b1;
      w_data = w_run;
      w_nxt  = (sink_eop || w_last) ? S_FLUSH : S_RUN;
    end else if (r_state == S_FLUSH && w_free) begin
      w_emit = 1'b1;
      w_data = w_fl;
      w_eop  = r_cur_eop;
      w_nxt  = r_cur_eop ? S_HDR : S_FIRST;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_HDR;
      r_alive      <= 1'b0;
      r_en         <= 1'b0;
      r_cur_eop    <= 1'b0;
      r_prev       <= '0;
      r_cur        <= '0;
      r_x          <= '0;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_state <= w_nxt;
      if (w_emit) begin
        source_valid <= 1'b1;
        source_data  <= w_data;
        source_sop   <= w_sop;
        source_eop   <= w_eop;
      end else if (source_ready) begin
        source_valid <= 1'b0;
      end
      if (w_acc && sink_sop) r_en <= enable;
      if (w_acc && !sink_sop && r_state == S_FIRST) begin
        r_prev    <= sink_data;
        r_cur     <= sink_data;
        r_x       <= '0;
        r_cur_eop <= sink_eop;
      end else if (w_acc && !sink_sop && r_state == S_RUN) begin
        r_prev    <= r_cur;
        r_cur     <= sink_data;
        r_x       <= r_x + 11'd1;
        r_cur_eop <= sink_eop;
      end
    end
  end
endmodule

// File: tb/tb_pixel_hsmooth.sv
// tb_pixel_hsmooth: self-checking bench for pixel_hsmooth against a packet-level smoothing model
module tb_pixel_hsmooth;
  localparam int W = 4;
  logic        clk, reset_n, sink_valid, sink_ready, sink_sop, sink_eop;
  logic        source_valid, source_ready, source_sop, source_eop, enable;
  logic [23:0] sink_data, source_data;
  int          checks = 0, errors = 0;
  logic [25:0] pkt[$], exp_q[$], got[$];
  bit          mon_on = 1'b1, rnd_ready = 1'b0;

  pixel_hsmooth #(.IMAGE_W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop), .enable(enable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 source_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // compare process: every transfer against the model queue, plus hold-stable under backpressure
  logic [25:0] held;
  bit          stall = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (!(source_valid && {source_sop, source_eop, source_data} == held)) begin
          errors++;
          $display("FAIL hold_stable got v=%0b %h want v=1 %h", source_valid, {source_sop, source_eop, source_data}, held);
        end
      end
      if (source_valid && source_ready && mon_on) begin
        checks++;
        got.push_back({source_sop, source_eop, source_data});
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word got %h want none", {source_sop, source_eop, source_data});
        end else begin
          if ({source_sop, source_eop, source_data} != exp_q[0]) begin
            errors++;
            $display("FAIL stream_word got %h want %h", {source_sop, source_eop, source_data}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      stall = source_valid && !source_ready;
      held  = {source_sop, source_eop, source_data};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] mfilt(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    logic [23:0] r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      int va = int'((a >> (8 * ch)) & 24'hFF);
      int vb = int'((b >> (8 * ch)) & 24'hFF);
      int vc = int'((c >> (8 * ch)) & 24'hFF);
      r = r | (24'((va + 2 * vb + vc + 2) / 4) << (8 * ch));
    end
    return r;
  endfunction

  // header forwarded; video packets cut into lines of W (last may be short), edges replicated
  task automatic model_pkt(input bit en);
    int s, n, sz;
    logic [23:0] a, b, c;
    sz = pkt.size();
    exp_q.push_back(pkt[0]);
    if (pkt[0][3:0] != 4'd0) begin
      for (int i = 1; i < sz; i++) exp_q.push_back(pkt[i]);
    end else begin
      s = 1;
      while (s < sz) begin
        n = (sz - s < W) ? sz - s : W;
        for (int k = 0; k < n; k++) begin
          a = pkt[s + ((k > 0) ? k - 1 : 0)][23:0];
          b = pkt[s + k][23:0];
          c = pkt[s + ((k < n - 1) ? k + 1 : k)][23:0];
          exp_q.push_back({1'b0, (s + k == sz - 1), en ? mfilt(a, b, c) : b});
        end
        s += n;
      end
    end
  endtask

  task automatic send_word(input logic [25:0] w, input bit gap);
    int n = 0;
    if (gap && $urandom_range(1, 0) == 1) begin
      sink_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    sink_valid = 1'b1;
    {sink_sop, sink_eop, sink_data} = w;
    @(negedge clk);
    while (!sink_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!sink_ready) begin
      checks++;
      errors++;
      $display("FAIL sink_timeout got ready=0 want ready=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input bit gaps);
    for (int i = 0; i < pkt.size(); i++) send_word(pkt[i], gaps);
    sink_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic run_pkt(input bit en, input bit gaps);
    enable = en;
    got.delete();
    model_pkt(en);
    send_pkt(gaps);
    drain();
  endtask

  task automatic mk_video(input int npix);
    pkt.delete();
    pkt.push_back(26'h2000000);
    for (int i = 0; i < npix; i++) pkt.push_back({1'b0, (i == npix - 1), 24'($urandom)});
  endtask

  task automatic mk_test1();
    pkt.delete();
    pkt.push_back(26'h2000000);
    pkt.push_back(26'h0000000);
    pkt.push_back(26'h0280000);
    pkt.push_back(26'h0500000);
    pkt.push_back(26'h1780000);
  endtask

  logic [25:0] lit1[5] = '{26'h2000000, 26'h00A0000, 26'h0280000, 26'h0500000, 26'h16E0000};
  logic [25:0] lit2[3] = '{26'h200000F, 26'h0123456, 26'h1ABCDEF};
  logic [25:0] lit5[4] = '{26'h2000000, 26'h0FFFFFF, 26'h0FFFFFF, 26'h1FFFFFF};

  initial begin
    reset_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0; enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", source_valid, 0);
    chk("rst_sop", source_sop, 0);
    chk("rst_eop", source_eop, 0);
    chk("rst_data", source_data, 0);
    chk("rst_ready", sink_ready, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", sink_ready, 1);
    @(posedge clk);
    #1;
    // test 1: filter a 4-pixel line, pinned by hand-computed values
    mk_test1();
    run_pkt(1'b1, 1'b0);
    chk("t1_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) chk($sformatf("t1_word%0d", k), got[k], lit1[k]);
    // stray non-sop word while waiting for a header is consumed and dropped
    pkt.delete();
    pkt.push_back(26'h0555555);
    send_pkt(1'b0);
    // test 2: non-video packet passes through bit-identical
    pkt.delete();
    pkt.push_back(26'h200000F);
    pkt.push_back(26'h0123456);
    pkt.push_back(26'h1ABCDEF);
    run_pkt(1'b1, 1'b0);
    chk("t2_count", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk($sformatf("t2_word%0d", k), got[k], lit2[k]);
    // test 3: random backpressure and input gaps
    rnd_ready = 1'b1;
    mk_test1();
    run_pkt(1'b1, 1'b1);
    for (int k = 0; k < 5 && k < got.size(); k++) chk($sformatf("t3_word%0d", k), got[k], lit1[k]);
    mk_video(2 * W + 3);
    run_pkt(1'b1, 1'b1);
    // test 4: bypass reproduces input word-for-word
    mk_video(4 * W);
    run_pkt(1'b0, 1'b1);
    rnd_ready = 1'b0;
    // test 5: early eop on the third pixel
    pkt.delete();
    pkt.push_back(26'h2000000);
    pkt.push_back(26'h0FFFFFF);
    pkt.push_back(26'h0FFFFFF);
    pkt.push_back(26'h1FFFFFF);
    run_pkt(1'b1, 1'b0);
    chk("t5_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk($sformatf("t5_word%0d", k), got[k], lit5[k]);
    // test 6: reset mid-line, then a full frame
    mon_on = 1'b0;
    enable = 1'b1;
    mk_video(2 * W);
    for (int i = 0; i < 3; i++) send_word(pkt[i], 1'b0);
    sink_valid = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t6_valid_after_rst", source_valid, 0);
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    rnd_ready = 1'b1;
    mk_video(2 * W);
    run_pkt(1'b1, 1'b1);
    rnd_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
